mac_seq_ctrl: RTL and testbench

//  Sequencer for one mac_unit accumulator (or the head of a MAC chain). Accepts a job of LEN operand

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_seq_ctrl_if.sv | 39 +++
 rtl/mac_ovf_mon.sv | 30 +++
 rtl/mac_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mac_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer and the MAC datapath.
package mac_pkg;

  localparam int WORD_SIZE_DFLT = 8;
  localparam int ACC_W_DFLT     = 2 * WORD_SIZE_DFLT + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Accumulator width for a given operand width: full product plus one carry bit.
  function automatic int acc_width(input int ws);
    return 2 * ws + 1;
  endfunction

  // Bits needed for a counter that must reach n (at least one bit).
  function automatic int ctr_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand, MAC and result signals of the MAC sequencer.
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DFLT,
  parameter int CNT_W     = 8
);

  localparam int ACC_W = acc_width(WORD_SIZE);

  logic                 start;
  logic [CNT_W-1:0]     len;
  logic                 busy;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_w;
  logic                 op_valid;
  logic                 op_ready;
  logic                 mac_clr;
  logic [WORD_SIZE-1:0] mac_ain;
  logic [WORD_SIZE-1:0] mac_win;
  logic [ACC_W-1:0]     mac_sout;
  logic [ACC_W-1:0]     res_data;
  logic                 res_ovf;
  logic                 res_valid;
  logic                 res_ready;

  // Environment side: job source, operand buffers, MAC and result consumer.
  modport master (
    output start, len, op_a, op_w, op_valid, mac_sout, res_ready,
    input  busy, op_ready, mac_clr, mac_ain, mac_win, res_data, res_ovf, res_valid
  );

  // Sequencer side.
  modport slave (
    input  start, len, op_a, op_w, op_valid, mac_sout, res_ready,
    output busy, op_ready, mac_clr, mac_ain, mac_win, res_data, res_ovf, res_valid
  );

endinterface

// File: rtl/mac_ovf_mon.sv
// Sticky wrap detector for a monotonically growing accumulator. Each sample is
// compared with the previous one; a decrease means the sum wrapped.
module mac_ovf_mon #(
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] sout,
  output logic             ovf
);

  logic [ACC_W-1:0] prev_sout;

  // Track the previous accumulator value and latch any decrease until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sout <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      prev_sout <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      prev_sout <= sout;
      if (sout < prev_sout) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one MAC accumulator: clear, stream LEN operand pairs, drain the
// MAC pipeline, then hold the wrapped sum and sticky wrap flag until taken.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DFLT,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input logic           clk,
  input logic           rst_n,
  mac_seq_ctrl_if.slave bus
);

  localparam int ACC_W = acc_width(WORD_SIZE);
  localparam int DC_W  = ctr_width(DRAIN_CYC);

  state_t           state, state_n;
  logic [CNT_W-1:0] rem;
  logic [DC_W-1:0]  dcnt;
  logic             hs;
  logic             drain_done;
  logic             mon_clr;
  logic             mon_en;
  logic             mon_ovf;

  assign bus.busy     = (state != IDLE);
  assign bus.op_ready = (state == FEED);
  assign hs           = bus.op_valid & bus.op_ready;
  // DRAIN lasts DRAIN_CYC+1 cycles so the wrap flag has seen the final sum
  // before it is captured alongside it.
  assign drain_done   = (state == DRAIN) && (dcnt == DC_W'(DRAIN_CYC));
  assign mon_clr      = (state == CLEAR);
  assign mon_en       = (state == FEED) || (state == DRAIN);

  mac_ovf_mon #(
    .ACC_W (ACC_W)
  ) u_ovf_mon (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mon_clr),
    .en    (mon_en),
    .sout  (bus.mac_sout),
    .ovf   (mon_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = CLEAR;
      CLEAR:   state_n = (rem != '0) ? FEED : DRAIN;
      FEED:    if (hs && (rem == CNT_W'(1))) state_n = DRAIN;
      DRAIN:   if (drain_done) state_n = DONE;
      DONE:    if (bus.res_valid && bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Remaining-pair and drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dcnt <= '0;
    end else begin
      if ((state == IDLE) && bus.start) rem <= bus.len;
      else if (hs)                      rem <= rem - CNT_W'(1);
      if (state != DRAIN)               dcnt <= '0;
      else if (!drain_done)             dcnt <= dcnt + DC_W'(1);
    end
  end

  // MAC operand registers and clear pulse; idle cycles feed zeros so the sum is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mac_ain <= '0;
      bus.mac_win <= '0;
      bus.mac_clr <= 1'b0;
    end else begin
      bus.mac_ain <= hs ? bus.op_a : '0;
      bus.mac_win <= hs ? bus.op_w : '0;
      bus.mac_clr <= (state_n == CLEAR);
    end
  end

  // Result capture at the end of the drain, held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_data  <= '0;
      bus.res_ovf   <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      if (drain_done) begin
        bus.res_data <= bus.mac_sout;
        bus.res_ovf  <= mon_ovf;
      end
      bus.res_valid <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC, table of directed jobs, random jobs
// checked against a sum-of-products model, and a mid-job reset sequence.
module tb_mac_seq_ctrl;

  localparam int WS  = 8;
  localparam int CW  = 8;
  localparam int DC  = 2;
  localparam int AW  = 2 * WS + 1;
  localparam longint MODV = 64'd1 << AW;

  logic clk;
  logic rst_n;
  logic [AW-1:0] acc;

  int n_chk  = 0;
  int n_fail = 0;
  int ja[$];
  int jw[$];

  mac_seq_ctrl_if #(.WORD_SIZE(WS), .CNT_W(CW)) bus ();

  mac_seq_ctrl #(
    .WORD_SIZE (WS),
    .CNT_W     (CW),
    .DRAIN_CYC (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: clear or reset zeroes the sum, otherwise add the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           acc <= '0;
    else if (bus.mac_clr) acc <= '0;
    else                  acc <= acc + AW'(32'(bus.mac_ain) * 32'(bus.mac_win));
  end
  assign bus.mac_sout = acc;

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] a;
    logic [3:0][7:0] w;
    logic [7:0]      gap_pos;
    logic [7:0]      gap_len;
    logic [7:0]      hold;
    logic            spur;
    logic [AW-1:0]   exp_data;
    logic            exp_ovf;
    logic [7:0]      exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " busy"},      64'(bus.busy),      64'd0);
    check({nm, " op_ready"},  64'(bus.op_ready),  64'd0);
    check({nm, " mac_clr"},   64'(bus.mac_clr),   64'd0);
    check({nm, " mac_ain"},   64'(bus.mac_ain),   64'd0);
    check({nm, " mac_win"},   64'(bus.mac_win),   64'd0);
    check({nm, " res_valid"}, 64'(bus.res_valid), 64'd0);
    check({nm, " res_ovf"},   64'(bus.res_ovf),   64'd0);
    check({nm, " res_data"},  64'(bus.res_data),  64'd0);
  endtask

  // One job from start to result handshake; pairs come from ja/jw.
  // exp_lat < 0 means derive it from the cycles spent feeding.
  task automatic run_job(input string nm, input int len, input int gap_pos, input int gap_len,
                         input int bub_pct, input int hold, input bit spur,
                         input logic [AW-1:0] exp_data, input bit exp_ovf, input int exp_lat);
    int c, idx, f, gap_rem, lat_exp;
    bit rdy_exp, vld, hs;
    logic [7:0] ain_exp, win_exp;
    bus.start    = 1'b1;
    bus.len      = 8'(len);
    bus.op_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.len   = 8'($urandom_range(255));
    c = 0; idx = 0; f = 0; gap_rem = gap_len;
    while (!bus.res_valid && c < 400) begin
      rdy_exp = (c >= 1) && (idx < len);
      vld = 1'b1;
      if (rdy_exp && idx == gap_pos && gap_rem > 0) begin
        vld = 1'b0;
        gap_rem--;
      end
      if (bub_pct > 0 && int'($urandom_range(99)) < bub_pct) vld = 1'b0;
      if (!rdy_exp) vld = ($urandom_range(1) == 1);
      bus.op_valid = vld;
      bus.op_a = (rdy_exp && vld) ? 8'(ja[idx]) : 8'($urandom_range(255));
      bus.op_w = (rdy_exp && vld) ? 8'(jw[idx]) : 8'($urandom_range(255));
      if (spur && c == 2) begin
        bus.start = 1'b1;
        bus.len   = 8'd5;
      end
      check({nm, " op_ready"}, 64'(bus.op_ready), 64'(rdy_exp));
      check({nm, " busy"},     64'(bus.busy),     64'd1);
      check({nm, " mac_clr"},  64'(bus.mac_clr),  64'(c == 0));
      hs = rdy_exp && vld;
      if (rdy_exp) f++;
      tick();
      c++;
      bus.start = 1'b0;
      ain_exp = hs ? 8'(ja[idx]) : 8'd0;
      win_exp = hs ? 8'(jw[idx]) : 8'd0;
      if (hs) idx++;
      check({nm, " mac_ain"}, 64'(bus.mac_ain), 64'(ain_exp));
      check({nm, " mac_win"}, 64'(bus.mac_win), 64'(win_exp));
    end
    bus.op_valid = 1'b0;
    lat_exp = (exp_lat >= 0) ? exp_lat : f + DC + 2;
    check({nm, " latency"},   64'(c),            64'(lat_exp));
    check({nm, " res_valid"}, 64'(bus.res_valid), 64'd1);
    check({nm, " res_data"},  64'(bus.res_data),  64'(exp_data));
    check({nm, " res_ovf"},   64'(bus.res_ovf),   64'(exp_ovf));
    bus.res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.start = (h == 1);
      bus.len   = 8'd3;
      tick();
      bus.start = 1'b0;
      check({nm, " hold res_valid"}, 64'(bus.res_valid), 64'd1);
      check({nm, " hold res_data"},  64'(bus.res_data),  64'(exp_data));
      check({nm, " hold res_ovf"},   64'(bus.res_ovf),   64'(exp_ovf));
    end
    bus.res_ready = 1'b1;
    bus.start     = spur;
    bus.len       = 8'd2;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check({nm, " ack res_valid"}, 64'(bus.res_valid), 64'd0);
    check({nm, " ack busy"},      64'(bus.busy),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint sum;
    int len, pct, hold;
    bit big, spur;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.op_a      = '0;
    bus.op_w      = '0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;

    tbl[0] = '{len: 8'd4, a: {8'd1, 8'd10, 8'd2, 8'd3}, w: {8'd1, 8'd10, 8'd7, 8'd5},
               gap_pos: 8'd255, gap_len: 8'd0, hold: 8'd0, spur: 1'b0,
               exp_data: AW'(130), exp_ovf: 1'b0, exp_lat: 8'd8};
    tbl[1] = '{len: 8'd4, a: {8'd1, 8'd10, 8'd2, 8'd3}, w: {8'd1, 8'd10, 8'd7, 8'd5},
               gap_pos: 8'd2, gap_len: 8'd3, hold: 8'd0, spur: 1'b0,
               exp_data: AW'(130), exp_ovf: 1'b0, exp_lat: 8'd11};
    tbl[2] = '{len: 8'd3, a: {8'd0, 8'd255, 8'd255, 8'd255}, w: {8'd0, 8'd255, 8'd255, 8'd255},
               gap_pos: 8'd255, gap_len: 8'd0, hold: 8'd0, spur: 1'b0,
               exp_data: AW'(64003), exp_ovf: 1'b1, exp_lat: 8'd7};
    tbl[3] = '{len: 8'd0, a: '0, w: '0,
               gap_pos: 8'd255, gap_len: 8'd0, hold: 8'd0, spur: 1'b1,
               exp_data: AW'(0), exp_ovf: 1'b0, exp_lat: 8'd4};
    tbl[4] = '{len: 8'd2, a: {8'd0, 8'd0, 8'd3, 8'd1}, w: {8'd0, 8'd0, 8'd4, 8'd2},
               gap_pos: 8'd255, gap_len: 8'd0, hold: 8'd5, spur: 1'b0,
               exp_data: AW'(14), exp_ovf: 1'b0, exp_lat: 8'd6};
    tbl[5] = '{len: 8'd1, a: {8'd0, 8'd0, 8'd0, 8'd4}, w: {8'd0, 8'd0, 8'd0, 8'd4},
               gap_pos: 8'd255, gap_len: 8'd0, hold: 8'd0, spur: 1'b0,
               exp_data: AW'(16), exp_ovf: 1'b0, exp_lat: 8'd5};

    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post-reset idle");

    // Directed jobs from the table.
    for (int i = 0; i < 6; i++) begin
      ja.delete();
      jw.delete();
      for (int k = 0; k < int'(tbl[i].len); k++) begin
        ja.push_back(int'(tbl[i].a[k]));
        jw.push_back(int'(tbl[i].w[k]));
      end
      run_job($sformatf("vec%0d", i), int'(tbl[i].len), int'(tbl[i].gap_pos),
              int'(tbl[i].gap_len), 0, int'(tbl[i].hold), tbl[i].spur,
              tbl[i].exp_data, tbl[i].exp_ovf, int'(tbl[i].exp_lat));
    end

    // Reset in the middle of feeding: nothing stale may come out afterwards.
    ja.delete();
    jw.delete();
    for (int k = 0; k < 4; k++) begin
      ja.push_back(k + 7);
      jw.push_back(k + 9);
    end
    bus.start = 1'b1;
    bus.len   = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = 8'(ja[k]);
      bus.op_w     = 8'(jw[k]);
      tick();
    end
    bus.op_valid = 1'b0;
    check("mid-feed busy before reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("after reset res_valid", 64'(bus.res_valid), 64'd0);
      check("after reset busy",      64'(bus.busy),      64'd0);
    end
    ja.delete();
    jw.delete();
    ja.push_back(4);
    jw.push_back(4);
    run_job("post-reset job", 1, 255, 0, 0, 0, 1'b0, AW'(16), 1'b0, 5);

    // Random jobs against a plain sum-of-products model.
    for (int j = 0; j < 24; j++) begin
      len  = int'($urandom_range(12));
      big  = ($urandom_range(2) == 0);
      pct  = int'($urandom_range(40));
      hold = int'($urandom_range(3));
      spur = ($urandom_range(1) == 1);
      ja.delete();
      jw.delete();
      sum = 0;
      for (int k = 0; k < len; k++) begin
        ja.push_back(big ? int'($urandom_range(255, 200)) : int'($urandom_range(255)));
        jw.push_back(big ? int'($urandom_range(255, 200)) : int'($urandom_range(255)));
        sum += longint'(ja[k]) * longint'(jw[k]);
      end
      run_job($sformatf("rand%0d", j), len, 255, 0, pct, hold, spur,
              AW'(sum % MODV), (sum >= MODV), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
